// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if: per-master request/response lanes plus the shared downstream bus.
interface bus_arbiter_if #(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [N_MASTERS-1:0] i_req_DV;
  logic [N_MASTERS*ADDR_W-1:0] i_req_address;
  logic [N_MASTERS*DATA_W-1:0] i_req_data;
  logic [N_MASTERS*3-1:0] i_req_bhw;
  logic [N_MASTERS-1:0] i_req_write_notread;
  logic [N_MASTERS-1:0] o_resp_DV;
  logic o_resp_err;
  logic [DATA_W-1:0] o_resp_data;
  logic [N_MASTERS-1:0] o_req_dropped;
  logic [ADDR_W-1:0] o_bus_address;
  logic [DATA_W-1:0] o_bus_data;
  logic [2:0] o_bhw;
  logic o_write_notread;
  logic o_bus_DV;
  logic [DATA_W-1:0] i_bus_data;
  logic i_bus_DV;
  modport slave (
    input i_req_DV, i_req_address, i_req_data, i_req_bhw, i_req_write_notread, i_bus_data, i_bus_DV,
    output o_resp_DV, o_resp_err, o_resp_data, o_req_dropped, o_bus_address, o_bus_data, o_bhw,
    output o_write_notread, o_bus_DV
  );
  modport master (
    output i_req_DV, i_req_address, i_req_data, i_req_bhw, i_req_write_notread, i_bus_data, i_bus_DV,
    input o_resp_DV, o_resp_err, o_resp_data, o_req_dropped, o_bus_address, o_bus_data, o_bhw,
    input o_write_notread, o_bus_DV
  );
endinterface

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin arbiter sharing one memory bus among N masters, with per-transaction timeout.
module bus_arbiter #(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TIMEOUT = 255
) (
  input logic i_clk,
  input logic i_rst_n,
  bus_arbiter_if.slave bus
);
  localparam int PW = $clog2(N_MASTERS);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [PW-1:0] G_LAST = PW'(N_MASTERS - 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t r_state, w_next;
  logic [N_MASTERS-1:0] r_pend, r_wnr, r_drop, r_resp;
  logic [ADDR_W-1:0] r_addr [N_MASTERS];
  logic [DATA_W-1:0] r_data [N_MASTERS];
  logic [2:0] r_bhw [N_MASTERS];
  logic [PW-1:0] r_ptr, r_grant, w_grant;
  logic [TW-1:0] r_timer;
  logic w_hit, w_done;
  int w_idx;
  logic r_bus_DV, r_bus_wnr, r_err;
  logic [ADDR_W-1:0] r_bus_addr;
  logic [DATA_W-1:0] r_bus_data, r_rdata;
  logic [2:0] r_bus_bhw;
  // Scanning from the farthest slot back to ptr leaves the first pending master at or after ptr.
  always_comb begin
    w_hit = 1'b0;
    w_grant = '0;
    w_idx = 0;
    for (int k = N_MASTERS - 1; k >= 0; k--) begin
      w_idx = int'(r_ptr) + k;
      w_idx = (w_idx >= N_MASTERS) ? w_idx - N_MASTERS : w_idx;
      if (r_pend[w_idx[PW-1:0]]) begin
        w_hit = 1'b1;
        w_grant = w_idx[PW-1:0];
      end
    end
  end
  // The response cycle itself is never a granting cycle, so back-to-back issues are spaced by IDLE, ISSUE.
  always_comb begin
    w_done = (r_state == WAIT) && (bus.i_bus_DV || (TIMEOUT != 0 && r_timer == T_LAST));
    w_next = (r_state == IDLE) ? ((w_hit && ~|r_resp) ? ISSUE : IDLE) :
             (r_state == ISSUE) ? WAIT :
             (w_done ? IDLE : WAIT);
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pend <= '0;
      r_wnr <= '0;
      r_drop <= '0;
      r_resp <= '0;
      for (int i = 0; i < N_MASTERS; i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
        r_bhw[i] <= '0;
      end
      r_ptr <= '0;
      r_grant <= '0;
      r_timer <= '0;
      r_bus_DV <= 1'b0;
      r_bus_wnr <= 1'b0;
      r_err <= 1'b0;
      r_bus_addr <= '0;
      r_bus_data <= '0;
      r_rdata <= '0;
      r_bus_bhw <= '0;
    end else begin
      r_drop <= bus.i_req_DV & r_pend;
      for (int i = 0; i < N_MASTERS; i++)
        if (bus.i_req_DV[i] && !r_pend[i]) begin
          r_pend[i] <= 1'b1;
          r_addr[i] <= bus.i_req_address[i*ADDR_W +: ADDR_W];
          r_data[i] <= bus.i_req_data[i*DATA_W +: DATA_W];
          r_bhw[i] <= bus.i_req_bhw[i*3 +: 3];
          r_wnr[i] <= bus.i_req_write_notread[i];
        end
      r_timer <= (r_state == WAIT) ? r_timer + 1'b1 : '0;
      r_bus_DV <= (w_next == ISSUE);
      if (w_next == ISSUE) begin
        r_grant <= w_grant;
        r_bus_addr <= r_addr[w_grant];
        r_bus_data <= r_data[w_grant];
        r_bus_bhw <= r_bhw[w_grant];
        r_bus_wnr <= r_wnr[w_grant];
      end
      r_resp <= '0;
      if (w_done) begin
        r_resp[r_grant] <= 1'b1;
        r_err <= ~bus.i_bus_DV;
        r_rdata <= bus.i_bus_DV ? bus.i_bus_data : '0;
        r_pend[r_grant] <= 1'b0;
        r_ptr <= (r_grant == G_LAST) ? '0 : r_grant + 1'b1;
      end
    end
  end
  assign bus.o_resp_DV = r_resp;
  assign bus.o_resp_err = r_err;
  assign bus.o_resp_data = r_rdata;
  assign bus.o_req_dropped = r_drop;
  assign bus.o_bus_address = r_bus_addr;
  assign bus.o_bus_data = r_bus_data;
  assign bus.o_bhw = r_bus_bhw;
  assign bus.o_write_notread = r_bus_wnr;
  assign bus.o_bus_DV = r_bus_DV;
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed scenarios plus randomized traffic against a round-robin reference model.
module tb_bus_arbiter;
  localparam int N = 3;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_pass = 0;
  bus_arbiter_if #(.N_MASTERS(N), .ADDR_W(32), .DATA_W(32)) ifc ();
  bus_arbiter #(.N_MASTERS(N), .ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .bus(ifc)
  );
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    tick;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] d, input logic [2:0] b, input logic w);
    ifc.i_req_DV[i] = 1'b1;
    ifc.i_req_address[i*32 +: 32] = a;
    ifc.i_req_data[i*32 +: 32] = d;
    ifc.i_req_bhw[i*3 +: 3] = b;
    ifc.i_req_write_notread[i] = w;
  endtask

  task automatic clr_req;
    ifc.i_req_DV = '0;
  endtask

  function automatic logic [N-1:0] oh(input int i);
    oh = '0;
    if (i >= 0 && i < N) oh[i] = 1'b1;
  endfunction

  task automatic serve(output logic [31:0] addr, output logic [N-1:0] resp, output bit ok);
    ok = 0;
    addr = '0;
    resp = '0;
    for (int k = 0; k < 20 && !ok; k++) begin
      if (ifc.o_bus_DV) begin
        addr = ifc.o_bus_address;
        tick;
        ifc.i_bus_DV = 1'b1;
        ifc.i_bus_data = addr ^ 32'hA5A5_0000;
        tick;
        ifc.i_bus_DV = 1'b0;
        resp = ifc.o_resp_DV;
        ok = 1;
      end else tick;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick;
    n_chk++;
    if ({ifc.o_resp_DV, ifc.o_resp_err, ifc.o_resp_data, ifc.o_req_dropped, ifc.o_bus_address, ifc.o_bus_data,
         ifc.o_bhw, ifc.o_write_notread, ifc.o_bus_DV} !== '0)
      $display("FAIL reset_outputs: got bus_DV=%b resp=%b addr=%h want all zero", ifc.o_bus_DV, ifc.o_resp_DV, ifc.o_bus_address);
    else n_pass++;
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_single_read;
    set_req(0, 32'h100, 32'h55, 3'b010, 1'b0);
    tick;
    clr_req;
    n_chk++;
    if (ifc.o_bus_DV !== 1'b0) $display("FAIL single_early: got bus_DV=%b want 0", ifc.o_bus_DV); else n_pass++;
    tick;
    n_chk++;
    if (ifc.o_bus_DV !== 1'b1 || ifc.o_bus_address !== 32'h100 || ifc.o_bhw !== 3'b010 || ifc.o_write_notread !== 1'b0 || ifc.o_bus_data !== 32'h55)
      $display("FAIL single_issue: got DV=%b addr=%h bhw=%b wnr=%b want 1 00000100 010 0", ifc.o_bus_DV, ifc.o_bus_address, ifc.o_bhw, ifc.o_write_notread);
    else n_pass++;
    tick;
    n_chk++;
    if (ifc.o_bus_DV !== 1'b0 || ifc.o_bus_address !== 32'h100) $display("FAIL single_pulse: got DV=%b addr=%h want 0 00000100", ifc.o_bus_DV, ifc.o_bus_address); else n_pass++;
    tick;
    ifc.i_bus_DV = 1'b1;
    ifc.i_bus_data = 32'hDEAD_BEEF;
    n_chk++;
    if (ifc.o_resp_DV !== 3'b000) $display("FAIL single_noresp: got %b want 000", ifc.o_resp_DV); else n_pass++;
    tick;
    ifc.i_bus_DV = 1'b0;
    n_chk++;
    if (ifc.o_resp_DV !== 3'b001 || ifc.o_resp_data !== 32'hDEAD_BEEF || ifc.o_resp_err !== 1'b0)
      $display("FAIL single_resp: got resp=%b data=%h err=%b want 001 deadbeef 0", ifc.o_resp_DV, ifc.o_resp_data, ifc.o_resp_err);
    else n_pass++;
    tick;
    n_chk++;
    if (ifc.o_resp_DV !== 3'b000) $display("FAIL single_resp_pulse: got %b want 000", ifc.o_resp_DV); else n_pass++;
  endtask

  task automatic test_fairness;
    logic [31:0] a;
    logic [N-1:0] rv;
    bit ok;
    int order [3];
    do_reset;
    for (int i = 0; i < N; i++) set_req(i, 32'h200 + i, 32'h0, 3'b011, 1'b1);
    tick;
    clr_req;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < N; i++) begin
        serve(a, rv, ok);
        n_chk++;
        if (!ok || a !== 32'h200 + i || rv !== oh(i))
          $display("FAIL fairness_r%0d_s%0d: got ok=%0d addr=%h resp=%b want addr=%h resp=%b", r, i, ok, a, rv, 32'h200 + i, oh(i));
        else n_pass++;
      end
      if (r == 0) begin
        for (int i = 0; i < N; i++) set_req(i, 32'h200 + i, 32'h0, 3'b011, 1'b1);
        tick;
        clr_req;
      end
    end
    order = '{2, 0, 2};
    set_req(2, 32'h2F2, 32'h0, 3'b000, 1'b0);
    tick;
    clr_req;
    serve(a, rv, ok);
    n_chk++;
    if (!ok || rv !== oh(2) || a !== 32'h2F2) $display("FAIL fairness_alone: got ok=%0d addr=%h resp=%b want 000002f2 100", ok, a, rv); else n_pass++;
    set_req(0, 32'h2E0, 32'h0, 3'b000, 1'b0);
    set_req(2, 32'h2E2, 32'h0, 3'b000, 1'b0);
    tick;
    clr_req;
    for (int i = 1; i < 3; i++) begin
      serve(a, rv, ok);
      n_chk++;
      if (!ok || rv !== oh(order[i]) || a !== 32'h2E0 + order[i])
        $display("FAIL fairness_pair%0d: got ok=%0d addr=%h resp=%b want resp=%b", i, ok, a, rv, oh(order[i]));
      else n_pass++;
    end
  endtask

  task automatic test_drop;
    bit seen = 0;
    tick;
    set_req(1, 32'h300, 32'h0, 3'b001, 1'b0);
    tick;
    set_req(1, 32'h301, 32'h0, 3'b001, 1'b0);
    n_chk++;
    if (ifc.o_req_dropped !== 3'b000) $display("FAIL drop_first: got %b want 000", ifc.o_req_dropped); else n_pass++;
    tick;
    clr_req;
    n_chk++;
    if (ifc.o_req_dropped !== 3'b010 || ifc.o_bus_DV !== 1'b1 || ifc.o_bus_address !== 32'h300)
      $display("FAIL drop_pulse: got drop=%b DV=%b addr=%h want 010 1 00000300", ifc.o_req_dropped, ifc.o_bus_DV, ifc.o_bus_address);
    else n_pass++;
    tick;
    ifc.i_bus_DV = 1'b1;
    ifc.i_bus_data = 32'h3333;
    n_chk++;
    if (ifc.o_req_dropped !== 3'b000) $display("FAIL drop_once: got %b want 000", ifc.o_req_dropped); else n_pass++;
    tick;
    ifc.i_bus_DV = 1'b0;
    n_chk++;
    if (ifc.o_resp_DV !== 3'b010 || ifc.o_resp_data !== 32'h3333) $display("FAIL drop_resp: got %b %h want 010 00003333", ifc.o_resp_DV, ifc.o_resp_data); else n_pass++;
    for (int k = 0; k < 6; k++) begin
      tick;
      seen |= ifc.o_bus_DV;
    end
    n_chk++;
    if (seen !== 1'b0) $display("FAIL drop_second_issued: got %b want 0", seen); else n_pass++;
  endtask

  task automatic test_rerequest;
    tick;
    set_req(0, 32'h400, 32'h0, 3'b010, 1'b0);
    tick;
    clr_req;
    tick;
    n_chk++;
    if (ifc.o_bus_DV !== 1'b1 || ifc.o_bus_address !== 32'h400) $display("FAIL rereq_issue: got %b %h want 1 00000400", ifc.o_bus_DV, ifc.o_bus_address); else n_pass++;
    tick;
    ifc.i_bus_DV = 1'b1;
    ifc.i_bus_data = 32'h4444;
    tick;
    ifc.i_bus_DV = 1'b0;
    n_chk++;
    if (ifc.o_resp_DV !== 3'b001) $display("FAIL rereq_resp: got %b want 001", ifc.o_resp_DV); else n_pass++;
    set_req(0, 32'h404, 32'h0, 3'b010, 1'b1);
    tick;
    clr_req;
    n_chk++;
    if (ifc.o_req_dropped !== 3'b000 || ifc.o_bus_DV !== 1'b0) $display("FAIL rereq_accept: got drop=%b DV=%b want 000 0", ifc.o_req_dropped, ifc.o_bus_DV); else n_pass++;
    tick;
    n_chk++;
    if (ifc.o_bus_DV !== 1'b1 || ifc.o_bus_address !== 32'h404 || ifc.o_write_notread !== 1'b1)
      $display("FAIL rereq_issue2: got %b %h wnr=%b want 1 00000404 1", ifc.o_bus_DV, ifc.o_bus_address, ifc.o_write_notread);
    else n_pass++;
    tick;
    ifc.i_bus_DV = 1'b1;
    ifc.i_bus_data = 32'h4040;
    tick;
    ifc.i_bus_DV = 1'b0;
    n_chk++;
    if (ifc.o_resp_DV !== 3'b001 || ifc.o_resp_data !== 32'h4040) $display("FAIL rereq_resp2: got %b %h want 001 00004040", ifc.o_resp_DV, ifc.o_resp_data); else n_pass++;
  endtask

  task automatic test_back_to_back;
    tick;
    set_req(1, 32'h510, 32'h0, 3'b000, 1'b0);
    set_req(2, 32'h520, 32'h0, 3'b000, 1'b0);
    tick;
    clr_req;
    tick;
    n_chk++;
    if (ifc.o_bus_DV !== 1'b1 || ifc.o_bus_address !== 32'h510) $display("FAIL b2b_first: got %b %h want 1 00000510", ifc.o_bus_DV, ifc.o_bus_address); else n_pass++;
    tick;
    ifc.i_bus_DV = 1'b1;
    ifc.i_bus_data = 32'h1;
    tick;
    ifc.i_bus_DV = 1'b0;
    n_chk++;
    if (ifc.o_resp_DV !== 3'b010) $display("FAIL b2b_resp1: got %b want 010", ifc.o_resp_DV); else n_pass++;
    tick;
    n_chk++;
    if (ifc.o_bus_DV !== 1'b0) $display("FAIL b2b_gap: got %b want 0", ifc.o_bus_DV); else n_pass++;
    tick;
    n_chk++;
    if (ifc.o_bus_DV !== 1'b1 || ifc.o_bus_address !== 32'h520) $display("FAIL b2b_second: got %b %h want 1 00000520", ifc.o_bus_DV, ifc.o_bus_address); else n_pass++;
    tick;
    ifc.i_bus_DV = 1'b1;
    ifc.i_bus_data = 32'h2;
    tick;
    ifc.i_bus_DV = 1'b0;
    n_chk++;
    if (ifc.o_resp_DV !== 3'b100) $display("FAIL b2b_resp2: got %b want 100", ifc.o_resp_DV); else n_pass++;
  endtask

  task automatic test_timeout;
    tick;
    set_req(0, 32'h600, 32'h0, 3'b010, 1'b0);
    set_req(1, 32'h610, 32'h0, 3'b010, 1'b0);
    tick;
    clr_req;
    tick;
    n_chk++;
    if (ifc.o_bus_DV !== 1'b1 || ifc.o_bus_address !== 32'h600) $display("FAIL tmo_issue: got %b %h want 1 00000600", ifc.o_bus_DV, ifc.o_bus_address); else n_pass++;
    for (int k = 0; k < 4; k++) tick;
    n_chk++;
    if (ifc.o_resp_DV !== 3'b000) $display("FAIL tmo_early: got %b want 000", ifc.o_resp_DV); else n_pass++;
    tick;
    n_chk++;
    if (ifc.o_resp_DV !== 3'b001 || ifc.o_resp_err !== 1'b1 || ifc.o_resp_data !== 32'h0)
      $display("FAIL tmo_resp: got resp=%b err=%b data=%h want 001 1 00000000", ifc.o_resp_DV, ifc.o_resp_err, ifc.o_resp_data);
    else n_pass++;
    ifc.i_bus_DV = 1'b1;
    ifc.i_bus_data = 32'hFFFF_FFFF;
    tick;
    n_chk++;
    if (ifc.o_resp_DV !== 3'b000 || ifc.o_bus_DV !== 1'b0) $display("FAIL tmo_stray1: got resp=%b DV=%b want 000 0", ifc.o_resp_DV, ifc.o_bus_DV); else n_pass++;
    tick;
    ifc.i_bus_DV = 1'b0;
    n_chk++;
    if (ifc.o_resp_DV !== 3'b000 || ifc.o_bus_DV !== 1'b1 || ifc.o_bus_address !== 32'h610)
      $display("FAIL tmo_next_issue: got resp=%b DV=%b addr=%h want 000 1 00000610", ifc.o_resp_DV, ifc.o_bus_DV, ifc.o_bus_address);
    else n_pass++;
    tick;
    ifc.i_bus_DV = 1'b1;
    ifc.i_bus_data = 32'h1234;
    tick;
    ifc.i_bus_DV = 1'b0;
    n_chk++;
    if (ifc.o_resp_DV !== 3'b010 || ifc.o_resp_err !== 1'b0 || ifc.o_resp_data !== 32'h1234)
      $display("FAIL tmo_next_resp: got resp=%b err=%b data=%h want 010 0 00001234", ifc.o_resp_DV, ifc.o_resp_err, ifc.o_resp_data);
    else n_pass++;
  endtask

  task automatic test_async_reset;
    logic [31:0] a;
    logic [N-1:0] rv;
    bit ok;
    bit seen = 0;
    tick;
    set_req(2, 32'h720, 32'h77, 3'b111, 1'b1);
    set_req(1, 32'h710, 32'h0, 3'b000, 1'b0);
    tick;
    clr_req;
    tick;
    n_chk++;
    if (ifc.o_bus_DV !== 1'b1 || ifc.o_bus_address !== 32'h720) $display("FAIL arst_issue: got %b %h want 1 00000720", ifc.o_bus_DV, ifc.o_bus_address); else n_pass++;
    tick;
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({ifc.o_resp_DV, ifc.o_resp_err, ifc.o_resp_data, ifc.o_req_dropped, ifc.o_bus_address, ifc.o_bus_data,
         ifc.o_bhw, ifc.o_write_notread, ifc.o_bus_DV} !== '0)
      $display("FAIL arst_outputs: got addr=%h data=%h bhw=%b want all zero", ifc.o_bus_address, ifc.o_bus_data, ifc.o_bhw);
    else n_pass++;
    #2 rst_n = 1'b1;
    tick;
    ifc.i_bus_DV = 1'b1;
    ifc.i_bus_data = 32'hBAD0_BAD0;
    for (int k = 0; k < 6; k++) begin
      tick;
      ifc.i_bus_DV = 1'b0;
      seen |= ifc.o_bus_DV | (|ifc.o_resp_DV);
    end
    n_chk++;
    if (seen !== 1'b0) $display("FAIL arst_quiet: got activity=%b want 0", seen); else n_pass++;
    set_req(1, 32'h711, 32'h0, 3'b000, 1'b0);
    set_req(2, 32'h722, 32'h0, 3'b000, 1'b0);
    tick;
    clr_req;
    for (int i = 1; i < 3; i++) begin
      serve(a, rv, ok);
      n_chk++;
      if (!ok || rv !== oh(i) || a !== 32'h700 + 32'h11 * i)
        $display("FAIL arst_ptr%0d: got ok=%0d addr=%h resp=%b want resp=%b", i, ok, a, rv, oh(i));
      else n_pass++;
    end
  endtask

  task automatic test_random;
    bit pv [N];
    logic [31:0] pa [N];
    logic [31:0] pd [N];
    logic [2:0] pb [N];
    logic pw [N];
    int rc [N];
    int ptr = 0;
    int cur = -1;
    int cnt = 0;
    int g;
    int j;
    bit due = 0;
    bit busy;
    logic [N-1:0] xdrop = '0;
    logic [N-1:0] ndrop;
    logic [N-1:0] xresp;
    logic [31:0] xdata = '0;
    logic [31:0] ra, rd;
    logic [2:0] rb;
    logic rw;
    do_reset;
    for (int i = 0; i < N; i++) begin
      pv[i] = 0;
      rc[i] = 0;
    end
    for (int cyc = 0; cyc < 1200; cyc++) begin
      tick;
      n_chk++;
      if (ifc.o_req_dropped !== xdrop) $display("FAIL rnd_drop@%0d: got %b want %b", cyc, ifc.o_req_dropped, xdrop); else n_pass++;
      xresp = due ? oh(cur) : '0;
      n_chk++;
      if (ifc.o_resp_DV !== xresp || (due && (ifc.o_resp_err !== 1'b0 || ifc.o_resp_data !== xdata)))
        $display("FAIL rnd_resp@%0d: got %b err=%b data=%h want %b data=%h", cyc, ifc.o_resp_DV, ifc.o_resp_err, ifc.o_resp_data, xresp, xdata);
      else n_pass++;
      if (due) begin
        if (cur >= 0) pv[cur] = 0;
        ptr = (cur + 1) % N;
        cur = -1;
        due = 0;
      end
      if (ifc.o_bus_DV) begin
        g = -1;
        for (int k = 0; k < N; k++) begin
          j = (ptr + k) % N;
          if (pv[j] && rc[j] <= cyc - 2) begin
            g = j;
            break;
          end
        end
        n_chk++;
        if (cur != -1 || g < 0 || ifc.o_bus_address !== pa[g] || ifc.o_bus_data !== pd[g] || ifc.o_bhw !== pb[g] || ifc.o_write_notread !== pw[g])
          $display("FAIL rnd_issue@%0d: got addr=%h data=%h want master %0d addr=%h", cyc, ifc.o_bus_address, ifc.o_bus_data, g, (g >= 0) ? pa[g] : 32'h0);
        else n_pass++;
        cur = g;
        cnt = $urandom_range(1, 3) + 1;
      end
      ifc.i_bus_DV = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          xdata = $urandom;
          ifc.i_bus_DV = 1'b1;
          ifc.i_bus_data = xdata;
          due = 1;
        end
      end else if (cur < 0 && $urandom_range(0, 7) == 0) begin
        ifc.i_bus_DV = 1'b1;
        ifc.i_bus_data = $urandom;
      end
      clr_req;
      ndrop = '0;
      if (cyc < 1000)
        for (int i = 0; i < N; i++)
          if ($urandom_range(0, 3) == 0) begin
            ra = $urandom;
            rd = $urandom;
            rb = 3'($urandom_range(0, 7));
            rw = 1'($urandom_range(0, 1));
            set_req(i, ra, rd, rb, rw);
            if (pv[i]) ndrop[i] = 1'b1;
            else begin
              pv[i] = 1;
              pa[i] = ra;
              pd[i] = rd;
              pb[i] = rb;
              pw[i] = rw;
              rc[i] = cyc;
            end
          end
      xdrop = ndrop;
    end
    busy = (cur != -1);
    for (int i = 0; i < N; i++) busy |= pv[i];
    n_chk++;
    if (busy) $display("FAIL rnd_drain: got outstanding work want none"); else n_pass++;
  endtask

  initial begin
    ifc.i_req_DV = '0;
    ifc.i_req_address = '0;
    ifc.i_req_data = '0;
    ifc.i_req_bhw = '0;
    ifc.i_req_write_notread = '0;
    ifc.i_bus_DV = 1'b0;
    ifc.i_bus_data = '0;
    tick;
    test_reset;
    test_single_read;
    test_fairness;
    test_drop;
    test_rerequest;
    test_back_to_back;
    test_timeout;
    test_async_reset;
    test_random;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
